wordmem_ctrl: RTL and testbench

Parametrised synchronous word memory, WIDTH x DEPTH, successor to the fixed 8-bit combinational byte cell array. Uses the same op/sel style of command (op=1 write, op=0 read), now clocked with a ready/valid handshake. Adds an automatic clear-all sweep after reset and on request, a registered read path, and out-of-range address flagging. Sits between the top-level test controller and the storage array.

---
 rtl/mem_pkg.sv | 12 +
 rtl/wordmem_ctrl_wordcell.sv | 23 ++
 rtl/wordmem_ctrl.sv | 128 ++++++++++++
 tb/tb_wordmem_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared command and state encodings for the word memory controller.
package mem_pkg;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/wordmem_ctrl_wordcell.sv
// Single WIDTH-bit storage word with a write enable.
// There is no reset because contents are initialised by the controller's clear sweep.
module wordcell #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] word_q;

    // Capture d on any enabled edge. Otherwise hold the stored value.
    always_ff @(posedge clk) begin
        if (we) begin
            word_q <= d;
        end
    end

    assign q = word_q;

endmodule

// File: rtl/wordmem_ctrl.sv
// Clocked WIDTH x DEPTH word memory with a sel/op command interface.
// It runs a clear-all sweep after reset and on request.
// The read path is registered, and accesses beyond DEPTH-1 raise err.
module wordmem_ctrl
    import mem_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 8,
    parameter logic [WIDTH-1:0] INIT_VAL = '0,
    localparam int              AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic             op,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] inp,
    input  logic             clr,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] outp,
    output logic             outp_valid,
    output logic             err
);

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] outp_q, outp_d;
    logic             outp_valid_q, outp_valid_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic             sweep;
    logic             in_range;
    logic             wr_en;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] cell_d;
    logic [DEPTH-1:0] cell_we;
    logic [WIDTH-1:0] word_q [DEPTH];

    assign sweep    = (state_q == ST_CLEAR);
    assign ready    = (state_q == ST_IDLE) && !clr;
    // Compare with one extra bit so that DEPTH itself is representable.
    assign in_range = ({1'b0, addr} < (AW + 1)'(DEPTH));
    assign wr_en    = sel && ready && (op == OP_WRITE) && in_range;
    assign cell_d   = sweep ? INIT_VAL : inp;

    // Storage words: a command write or the sweep write enables each word.
    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        assign cell_we[i] = (wr_en && (addr == AW'(i))) || (sweep && (cnt_q == AW'(i)));
        wordcell #(.WIDTH(WIDTH)) u_cell (
            .clk (clk),
            .we  (cell_we[i]),
            .d   (cell_d),
            .q   (word_q[i])
        );
    end

    // Read mux. Out-of-range addresses select zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == AW'(i)) begin
                rd_data = word_q[i];
            end
        end
    end

    // Next-state and registered-output logic for the CLEAR/IDLE controller.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        outp_d       = outp_q;
        outp_valid_d = 1'b0;
        err_d        = 1'b0;
        busy_d       = busy_q;
        case (state_q)
            ST_CLEAR: begin
                // Stop on the last real word so that non-power-of-two depths never wrap.
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else if (sel) begin
                    err_d = !in_range;
                    if (op == OP_READ) begin
                        outp_d       = in_range ? rd_data : '0;
                        outp_valid_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // Controller state and output registers. Reset starts a fresh sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            cnt_q        <= '0;
            outp_q       <= '0;
            outp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            outp_q       <= outp_d;
            outp_valid_q <= outp_valid_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign outp       = outp_q;
    assign outp_valid = outp_valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_wordmem_ctrl.sv
// Directed bench for wordmem_ctrl.
// Instance A is 8 words deep with INIT_VAL 0; instance B is 6 words deep with INIT_VAL 0x3C.
module tb_wordmem_ctrl;

    logic       clk = 1'b0;
    int         checks = 0;
    int         errors = 0;

    // Instance A: 8 words deep, INIT_VAL 0
    logic       rst_n, sel, op, clr;
    logic [2:0] addr;
    logic [7:0] inp;
    logic       ready, busy, outp_valid, err;
    logic [7:0] outp;

    // Instance B: 6 words deep, INIT_VAL 0x3C
    logic       rst_n_b, sel_b, op_b, clr_b;
    logic [2:0] addr_b;
    logic [7:0] inp_b;
    logic       ready_b, busy_b, outp_valid_b, err_b;
    logic [7:0] outp_b;

    always #5 clk = ~clk;

    wordmem_ctrl #(.WIDTH(8), .DEPTH(8), .INIT_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .op(op), .addr(addr), .inp(inp),
        .clr(clr), .ready(ready), .busy(busy), .outp(outp),
        .outp_valid(outp_valid), .err(err)
    );

    wordmem_ctrl #(.WIDTH(8), .DEPTH(6), .INIT_VAL(8'h3C)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .sel(sel_b), .op(op_b), .addr(addr_b), .inp(inp_b),
        .clr(clr_b), .ready(ready_b), .busy(busy_b), .outp(outp_b),
        .outp_valid(outp_valid_b), .err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read one address on instance A and check the response one cycle later.
    task automatic rd_a(input logic [2:0] a, input logic [7:0] exp, input string tag);
        sel = 1'b1; op = 1'b0; addr = a;
        tick();
        sel = 1'b0;
        chk({tag, "_valid"}, outp_valid, 1'b1);
        chk({tag, "_data"}, outp, exp);
        chk({tag, "_err"}, err, 1'b0);
    endtask

    task automatic wr_a(input logic [2:0] a, input logic [7:0] d);
        sel = 1'b1; op = 1'b1; addr = a; inp = d;
        tick();
        sel = 1'b0;
    endtask

    task automatic rd_b(input logic [2:0] a, input logic [7:0] exp, input logic exp_err, input string tag);
        sel_b = 1'b1; op_b = 1'b0; addr_b = a;
        tick();
        sel_b = 1'b0;
        chk({tag, "_valid"}, outp_valid_b, 1'b1);
        chk({tag, "_data"}, outp_b, exp);
        chk({tag, "_err"}, err_b, exp_err);
    endtask

    // Count the cycles during which instance A reports busy (bounded).
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n = 1'b1; sel = 1'b0; op = 1'b0; clr = 1'b0; addr = '0; inp = '0;
        rst_n_b = 1'b1; sel_b = 1'b0; op_b = 1'b0; clr_b = 1'b0; addr_b = '0; inp_b = '0;
        #2;
        rst_n = 1'b0; rst_n_b = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b1);
        chk("rst_ready", ready, 1'b0);
        chk("rst_outp", outp, 8'h00);
        chk("rst_valid", outp_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; rst_n_b = 1'b1;

        // 1: the sweep lasts 8 cycles, then every word reads 0
        count_busy(n);
        chk("sweep_len", n, 8);
        chk("ready_after_sweep", ready, 1'b1);
        for (int i = 0; i < 8; i++) rd_a(3'(i), 8'h00, "init_rd");

        // 2: write then read the same address on the next cycle
        wr_a(3'd3, 8'hA5);
        chk("wr_no_valid", outp_valid, 1'b0);
        chk("wr_no_err", err, 1'b0);
        rd_a(3'd3, 8'hA5, "rd_after_wr");
        tick(); tick();
        chk("hold_data", outp, 8'hA5);
        chk("hold_valid", outp_valid, 1'b0);

        // 3: back-to-back writes and reads
        wr_a(3'd1, 8'h11); wr_a(3'd2, 8'h22); wr_a(3'd3, 8'h33);
        sel = 1'b1; op = 1'b0; addr = 3'd1; tick();
        chk("b2b_v1", outp_valid, 1'b1); chk("b2b_d1", outp, 8'h11);
        addr = 3'd2; tick();
        chk("b2b_v2", outp_valid, 1'b1); chk("b2b_d2", outp, 8'h22);
        addr = 3'd3; tick();
        chk("b2b_v3", outp_valid, 1'b1); chk("b2b_d3", outp, 8'h33);
        sel = 1'b0; tick();
        chk("b2b_v_end", outp_valid, 1'b0);

        // 4: instance B, 6 words deep, out-of-range accesses
        chk("b_ready", ready_b, 1'b1);
        sel_b = 1'b1; op_b = 1'b1; addr_b = 3'd0; inp_b = 8'h77; tick(); sel_b = 1'b0;
        chk("b_wr_ok_err", err_b, 1'b0);
        rd_b(3'd5, 8'h3C, 1'b0, "b_rd5");
        sel_b = 1'b1; op_b = 1'b1; addr_b = 3'd7; inp_b = 8'hEE; tick(); sel_b = 1'b0;
        chk("b_wr_oor_err", err_b, 1'b1);
        chk("b_wr_oor_valid", outp_valid_b, 1'b0);
        rd_b(3'd6, 8'h00, 1'b1, "b_rd_oor");
        tick();
        chk("b_err_pulse", err_b, 1'b0);
        chk("b_valid_pulse", outp_valid_b, 1'b0);
        rd_b(3'd0, 8'h77, 1'b0, "b_rd0");
        for (int i = 1; i < 6; i++) rd_b(3'(i), 8'h3C, 1'b0, "b_words");

        // 5: clr and a write in the same cycle; the write is refused
        clr = 1'b1; sel = 1'b1; op = 1'b1; addr = 3'd2; inp = 8'hFF;
        #1;
        chk("clr_ready", ready, 1'b0);
        tick();
        clr = 1'b0; sel = 1'b0;
        chk("clr_err", err, 1'b0);
        count_busy(n);
        chk("clr_sweep_len", n, 8);
        rd_a(3'd2, 8'h00, "clr_rd2");
        rd_a(3'd3, 8'h00, "clr_rd3");

        // 6a: reset at sweep cycle 4 restarts the full sweep
        clr = 1'b1; tick(); clr = 1'b0;
        tick(); tick(); tick(); tick();
        chk("mid_sweep_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(n);
        chk("resweep_len", n, 8);

        // 6b: reset with a read in flight discards the response
        wr_a(3'd4, 8'h5A);
        rd_a(3'd4, 8'h5A, "pre_rst_rd");
        sel = 1'b1; op = 1'b0; addr = 3'd4;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rd_rst_outp", outp, 8'h00);
        chk("rd_rst_valid", outp_valid, 1'b0);
        @(posedge clk);
        #1;
        sel = 1'b0;
        chk("rd_rst_no_stale", outp_valid, 1'b0);
        chk("rd_rst_outp2", outp, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(n);
        chk("rst_resweep_len", n, 8);
        rd_a(3'd4, 8'h00, "post_rst_rd4");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
